// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: arms a programmable Mealy pattern detector for a bounded window of valid bits and counts hits.
// Define SEQ_DETECT_CTRL_ABORT_EN to add the abort input and sticky aborted output.
module seq_detect_ctrl #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             in_valid,
  input  logic             in_seq,
`ifdef SEQ_DETECT_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic             det_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             thresh_hit
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] pat, shifted;
  logic [WIN_W-1:0] bits, win;
  logic [CNT_W-1:0] thr, cnt_nxt;
  logic abt, acc, last, launch;
`ifdef SEQ_DETECT_CTRL_ABORT_EN
  assign abt = abort & busy;
`else
  assign abt = 1'b0;
`endif
  assign busy      = state == ARM || state == RUN;
  assign done      = state == DONE;
  assign launch    = state == IDLE && start;
  assign shifted   = {hist, in_seq};
  assign acc       = state == RUN && in_valid && !abt && win != '0;
  assign det_pulse = acc && bits >= WIN_W'(PAT_W - 1) && shifted == pat;
  assign last      = acc && bits == win - WIN_W'(1);
  assign cnt_nxt   = &match_cnt ? match_cnt : match_cnt + CNT_W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? ARM : IDLE;
      ARM:     state_nxt = abt ? DONE : RUN;
      RUN:     state_nxt = (abt || win == '0 || last) ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hist       <= '0;
      bits       <= '0;
      pat        <= '0;
      win        <= '0;
      thr        <= '0;
      match_cnt  <= '0;
      thresh_hit <= 1'b0;
    end else if (launch) begin
      hist       <= '0;
      bits       <= '0;
      pat        <= cfg_pattern;
      win        <= cfg_window;
      thr        <= cfg_thresh;
      match_cnt  <= '0;
      thresh_hit <= 1'b0;
    end else if (acc) begin
      hist <= shifted[PAT_W-2:0];
      bits <= bits + WIN_W'(1);
      if (det_pulse) begin
        match_cnt <= cnt_nxt;
        if (thr != '0 && cnt_nxt >= thr) thresh_hit <= 1'b1;
      end
    end
`ifdef SEQ_DETECT_CTRL_ABORT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) aborted <= 1'b0;
    else if (launch) aborted <= 1'b0;
    else if (abt) aborted <= 1'b1;
`endif
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed vector bench for seq_detect_ctrl (default and CNT_W=2/PAT_W=2 instances).
module tb_seq_detect_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, in_seq = 1'b0;
  logic [2:0] cfg_pattern = '0;
  logic [15:0] cfg_window = '0;
  logic [7:0] cfg_thresh = '0;
  logic busy, done, det_pulse, thresh_hit;
  logic [7:0] match_cnt;
  logic start2 = 1'b0, in_valid2 = 1'b0, in_seq2 = 1'b0;
  logic [1:0] cfg_pattern2 = '0, cfg_thresh2 = '0, match_cnt2;
  logic [15:0] cfg_window2 = '0;
  logic busy2, done2, det2, th2;
`ifdef SEQ_DETECT_CTRL_ABORT_EN
  logic abort = 1'b0, aborted, abort2 = 1'b0, aborted2;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl u1 (
    .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_window(cfg_window), .cfg_thresh(cfg_thresh), .in_valid(in_valid), .in_seq(in_seq),
`ifdef SEQ_DETECT_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .det_pulse(det_pulse), .match_cnt(match_cnt), .thresh_hit(thresh_hit)
  );

  seq_detect_ctrl #(.PAT_W(2), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .cfg_pattern(cfg_pattern2),
    .cfg_window(cfg_window2), .cfg_thresh(cfg_thresh2), .in_valid(in_valid2), .in_seq(in_seq2),
`ifdef SEQ_DETECT_CTRL_ABORT_EN
    .abort(abort2), .aborted(aborted2),
`endif
    .busy(busy2), .done(done2), .det_pulse(det2), .match_cnt(match_cnt2), .thresh_hit(th2)
  );

  typedef struct {
    logic v;
    logic b;
    logic det;
    logic [7:0] cnt;
    logic th;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves u1 in RUN; ARM cycle presents a valid bit that must be ignored.
  task automatic do_start(input logic [2:0] p, input logic [15:0] w, input logic [7:0] t);
    cfg_pattern = p; cfg_window = w; cfg_thresh = t; start = 1'b1;
    tick;
    start = 1'b0;
    cfg_pattern = ~p; cfg_window = 16'd1; cfg_thresh = 8'd0;
    chk("arm_busy", busy, 1);
    chk("arm_cnt_clear", match_cnt, 0);
    chk("arm_th_clear", thresh_hit, 0);
    in_valid = 1'b1; in_seq = 1'b1;
    #1 chk("arm_det", det_pulse, 0);
    tick;
    in_valid = 1'b0;
  endtask

  vec_t tv[8];
  logic b3[6];

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tv[2] = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b0};
    tv[3] = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tv[4] = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tv[5] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b1};
    tv[6] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b1};
    tv[7] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1};
    b3 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det", det_pulse, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_th", thresh_hit, 0);
    reset = 1'b1;
    tick;

    do_start(3'b001, 16'd8, 8'd2);
    for (int i = 0; i < 8; i++) begin
      in_valid = tv[i].v; in_seq = tv[i].b;
      #1 chk($sformatf("t2_det%0d", i + 1), det_pulse, tv[i].det);
      tick;
      chk($sformatf("t2_cnt%0d", i + 1), match_cnt, tv[i].cnt);
      chk($sformatf("t2_th%0d", i + 1), thresh_hit, tv[i].th);
      if (i < 7) chk($sformatf("t2_busy%0d", i + 1), busy, 1);
    end
    in_valid = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_done_busy", busy, 0);
    tick;
    chk("t2_done_pulse", done, 0);
    chk("t2_cnt_hold", match_cnt, 2);

    do_start(3'b001, 16'd6, 8'd0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0 && k < 4)
        for (int g = 0; g < 3; g++) begin
          in_valid = 1'b0; start = (g == 1);
          tick;
          chk("t3_gap_done", done, 0);
        end
      start = 1'b0;
      in_valid = 1'b1; in_seq = b3[k];
      tick;
      in_valid = 1'b0;
      chk($sformatf("t3_done%0d", k + 1), done, k == 5);
    end
    chk("t3_cnt", match_cnt, 1);
    tick;

    do_start(3'b001, 16'd0, 8'd1);
    in_valid = 1'b1; in_seq = 1'b1;
    #1 chk("t4_det", det_pulse, 0);
    chk("t4_run_done", done, 0);
    tick;
    in_valid = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_cnt", match_cnt, 0);
    chk("t4_th", thresh_hit, 0);
    tick;

    do_start(3'b001, 16'd8, 8'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_seq = (i == 2);
      tick;
    end
    chk("t1_pre_cnt", match_cnt, 1);
    chk("t1_pre_th", thresh_hit, 1);
    in_valid = 1'b1; in_seq = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_det", det_pulse, 0);
    chk("t1_cnt", match_cnt, 0);
    chk("t1_th", thresh_hit, 0);
    chk("t1_done", done, 0);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t1_no_done", done, 0);
      chk("t1_idle", busy, 0);
    end

    cfg_pattern2 = 2'b00; cfg_window2 = 16'd10; cfg_thresh2 = 2'd0; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    tick;
    for (int i = 1; i <= 10; i++) begin
      in_valid2 = 1'b1; in_seq2 = 1'b0;
      #1 chk($sformatf("t5_det%0d", i), det2, i >= 2);
      tick;
      chk($sformatf("t5_cnt%0d", i), match_cnt2, (i - 1 > 3) ? 3 : i - 1);
      chk($sformatf("t5_th%0d", i), th2, 0);
    end
    in_valid2 = 1'b0;
    chk("t5_done", done2, 1);
    tick;

`ifdef SEQ_DETECT_CTRL_ABORT_EN
    do_start(3'b001, 16'd8, 8'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_seq = (i == 2);
      tick;
    end
    abort = 1'b1; in_valid = 1'b1; in_seq = 1'b1;
    #1 chk("ab_det", det_pulse, 0);
    tick;
    abort = 1'b0; in_valid = 1'b0;
    chk("ab_done", done, 1);
    chk("ab_flag", aborted, 1);
    chk("ab_cnt", match_cnt, 1);
    tick;
    chk("ab_sticky", aborted, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_idle_ignored", busy, 0);
    do_start(3'b001, 16'd8, 8'd0);
    chk("ab_clear", aborted, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Controller that arms, sequences and reports a programmable-pattern serial sequence detector over a bounded observation window.
- Sits between a host/config agent and the serial input stream.
- Latches configuration on `start`, runs the embedded Mealy detector for exactly `cfg_window` valid bits, and counts detections (overlapping allowed).
- Signals completion and threshold crossing back to the host.

Parameters:
- PAT_W, 3, pattern length in bits (≥2).
- CNT_W, 8, match counter width.
- WIN_W, 16, window-length field width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  start request; sampled only in IDLE.
- cfg_pattern  input  PAT_W  target pattern; MSB is the oldest bit.
- cfg_window  input  WIN_W  number of valid input bits to observe.
- cfg_thresh  input  CNT_W  match-count threshold; 0 disables `thresh_hit`.
- in_valid  input  1  `in_seq` qualifier.
- in_seq  input  1  serial data bit.
- busy  output  1  high in ARM and RUN.
- done  output  1  one-cycle completion pulse.
- det_pulse  output  1  combinational Mealy detect, same cycle as the completing bit.
- match_cnt  output  CNT_W  detections in the current/last run.
- thresh_hit  output  1  sticky threshold flag.

Behaviour:
- Reset (reset=0, async): state=IDLE; history, bit counter, shadow config, `match_cnt`, `thresh_hit` cleared to 0. `busy`, `done`, `det_pulse` are 0 immediately. Applies mid-run too: the run is discarded and `done` is not pulsed.
- States: IDLE, ARM, RUN, DONE (2-bit encoding, default → IDLE).
- IDLE:
  - busy=0.
  - start=1 → latch cfg_pattern/cfg_window/cfg_thresh into shadow regs; clear `match_cnt`, `thresh_hit`, history, bit counter; → ARM.
- ARM: one cycle, busy=1; → RUN. In ARM, `in_valid` is ignored.
- RUN:
  - busy=1.
  - Shadow `cfg_window`==0 → DONE on the next edge; no bits consumed.
  - Each cycle with in_valid=1: accept the bit. The history shifts left with `in_seq` entering the LSB, and the bit counter increments.
  - det_pulse = in_valid & (bits_seen ≥ PAT_W-1) & ({hist[PAT_W-2:0], in_seq} == shadow pattern). Combinational, no latency.
  - Detection → `match_cnt` increments on the same edge, saturating at 2^CNT_W-1.
  - Overlap: history is not cleared on a match (001001 with pattern 001 → 2 hits; 0000 with pattern 00 → 3 hits).
  - When the accepted bit is bit number `cfg_window` → DONE on that edge.
  - in_valid=0 cycles hold all state.
- DONE: done=1 for exactly one cycle, busy=0; → IDLE. `match_cnt` holds its value until the next start.
- thresh_hit:
  - Set on the edge where match_cnt becomes ≥ shadow thresh (thresh≠0).
  - Sticky until the next accepted start or reset.
  - Never set when thresh=0.
- Ignored inputs:
  - `start` in ARM/RUN/DONE is ignored; it is not queued.
  - `cfg_*` changes after latch have no effect.
  - `in_valid` outside RUN is ignored; det_pulse=0 outside RUN.
- Latency: start edge → busy=1 next cycle. Last window bit accepted → done=1 next cycle.

Optional Feature:
- Macro SEQ_DETECT_CTRL_ABORT_EN.
- Defined:
  - Adds port `abort` (input, 1) and output `aborted` (1, sticky).
  - abort=1 in ARM or RUN → DONE on the next edge. The bit presented that cycle is not accepted and det_pulse is forced 0.
  - `aborted` is set; done pulses normally. `aborted` is cleared on start/reset.
  - abort in IDLE/DONE is ignored.
- Undefined: neither port exists; behaviour is as above.

Test Plan:
- Reset=0 pulse at arbitrary phase mid-RUN → all outputs 0 within the same cycle, state IDLE, no `done` pulse.
- Config pattern 3'b001, window 8, thresh 2; stream 0,0,1,0,0,1,1,0 all valid → det_pulse on bits 3 and 6, match_cnt=2, thresh_hit set at bit 6, done one cycle after bit 8.
- Window 6, stream 1,0,0,1 with in_valid gaps of 3 cycles between bits, then 0,0 → match_cnt=1, done only after the 6th valid bit. start pulses during RUN ignored (match_cnt not cleared).
- Window 0 → start, ARM, RUN, DONE: done on the 3rd cycle after start, match_cnt=0, thresh_hit=0.
- CNT_W=2, pattern 2'b00, window 10, all zeros → 9 raw hits, match_cnt saturates at 3. Thresh 0 → thresh_hit stays 0.
- (ABORT_EN) abort in cycle 4 of RUN → done next cycle, aborted=1, match_cnt holds its partial count. A new start clears aborted.
